// File: rtl/osd_cmd_arbiter_if.sv
// Requester handshake and OSD command bus bundle for osd_cmd_arbiter.
// master = requester/OSD-side view, slave = arbiter view.
interface osd_cmd_arbiter_if;
    logic        req0_valid;
    logic        req0_last;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic        req1_last;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic        io_osd;
    logic        io_strobe;
    logic [15:0] io_din;
    logic        busy;
    logic [1:0]  grant;
    logic [7:0]  abort_cnt;

    modport master (
        output req0_valid, req0_last, req0_data,
        input  req0_ready,
        output req1_valid, req1_last, req1_data,
        input  req1_ready,
        input  io_osd, io_strobe, io_din, busy, grant, abort_cnt
    );

    modport slave (
        input  req0_valid, req0_last, req0_data,
        output req0_ready,
        input  req1_valid, req1_last, req1_data,
        output req1_ready,
        output io_osd, io_strobe, io_din, busy, grant, abort_cnt
    );
endinterface

// File: rtl/osd_cmd_arbiter.sv
// Packet-granular arbiter for the OSD command bus with io_osd framing and io_strobe timing.
// Define OSD_ARB_PRIO_EN for strict req0 priority instead of round-robin.
module osd_cmd_arbiter #(
    parameter int unsigned STROBE_HI = 2,
    parameter int unsigned STROBE_LO = 2,
    parameter int unsigned GAP       = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    osd_cmd_arbiter_if.slave   bus
);

    localparam int unsigned PMAX0 = (STROBE_HI > STROBE_LO) ? STROBE_HI : STROBE_LO;
    localparam int unsigned PMAX  = (PMAX0 > GAP) ? PMAX0 : GAP;
    localparam int unsigned PW    = $clog2(PMAX + 1);
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_HI,
        S_LO,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic            own_q, own_d;       // 0 = req0, 1 = req1
    logic [PW-1:0]   ph_q, ph_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            last_q, last_d;
    logic [15:0]     din_q, din_d;
    logic [7:0]      abort_q, abort_d;
    logic            osd_q, osd_d;
    logic            stb_q, stb_d;
    logic            busy_q, busy_d;
    logic [1:0]      grant_q, grant_d;
`ifndef OSD_ARB_PRIO_EN
    logic            rr_q, rr_d;         // 1 = req1 wins a tie
`endif

    logic            sel_valid;
    logic            sel_last;
    logic [15:0]     sel_data;
    logic            accept;

    assign sel_valid = own_q ? bus.req1_valid : bus.req0_valid;
    assign sel_last  = own_q ? bus.req1_last  : bus.req0_last;
    assign sel_data  = own_q ? bus.req1_data  : bus.req0_data;

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ph_d    = ph_q;
        tmo_d   = tmo_q;
        last_d  = last_q;
        din_d   = din_q;
        abort_d = abort_q;
`ifndef OSD_ARB_PRIO_EN
        rr_d    = rr_q;
`endif
        accept  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
`ifdef OSD_ARB_PRIO_EN
                    own_d = ~bus.req0_valid;
`else
                    own_d = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
`endif
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sel_valid) begin
                    accept  = 1'b1;
                    din_d   = sel_data;
                    last_d  = sel_last;
                    tmo_d   = '0;
                    ph_d    = '0;
                    state_d = S_HI;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    ph_d    = '0;
                    state_d = S_GAP;
                    if (abort_q != '1) abort_d = abort_q + 8'd1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_HI: begin
                if (ph_q == PW'(STROBE_HI - 1)) begin
                    ph_d    = '0;
                    state_d = S_LO;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_LO: begin
                if (ph_q == PW'(STROBE_LO - 1)) begin
                    ph_d    = '0;
                    state_d = last_q ? S_GAP : S_WAIT;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_GAP: begin
`ifndef OSD_ARB_PRIO_EN
                rr_d = ~own_q;
`endif
                if (ph_q == PW'(GAP - 1)) begin
                    ph_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so the OSD sees glitch-free edges.
        osd_d   = (state_d == S_SETUP) || (state_d == S_WAIT) ||
                  (state_d == S_HI)    || (state_d == S_LO);
        stb_d   = (state_d == S_HI);
        busy_d  = (state_d != S_IDLE);
        grant_d = osd_d ? (own_d ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            own_q   <= 1'b0;
            ph_q    <= '0;
            tmo_q   <= '0;
            last_q  <= 1'b0;
            din_q   <= '0;
            abort_q <= '0;
            osd_q   <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= '0;
`ifndef OSD_ARB_PRIO_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ph_q    <= ph_d;
            tmo_q   <= tmo_d;
            last_q  <= last_d;
            din_q   <= din_d;
            abort_q <= abort_d;
            osd_q   <= osd_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
`ifndef OSD_ARB_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign bus.req0_ready = accept & ~own_q;
    assign bus.req1_ready = accept &  own_q;
    assign bus.io_osd     = osd_q;
    assign bus.io_strobe  = stb_q;
    assign bus.io_din     = din_q;
    assign bus.busy       = busy_q;
    assign bus.grant      = grant_q;
    assign bus.abort_cnt  = abort_q;

endmodule

// File: tb/tb_osd_cmd_arbiter.sv
// Scoreboard bench for osd_cmd_arbiter: requester drivers, a word/arbitration monitor and directed timing checks.
module tb_osd_cmd_arbiter;

    localparam int unsigned SHI  = 2;
    localparam int unsigned SLO  = 2;
    localparam int unsigned GAPC = 4;
    localparam int unsigned TMO  = 255;

    localparam int SEL_STB  = 0;
    localparam int SEL_OSD  = 1;
    localparam int SEL_BUSY = 2;
    localparam int SEL_V0   = 3;
    localparam int SEL_R0   = 4;

    typedef struct {
        logic        last;
        logic [15:0] data;
        int unsigned dly;
    } word_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    osd_cmd_arbiter_if bus();

    osd_cmd_arbiter #(
        .STROBE_HI (SHI),
        .STROBE_LO (SLO),
        .GAP       (GAPC),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic        drv_valid [2];
    logic        drv_last  [2];
    logic [15:0] drv_data  [2];

    assign bus.req0_valid = drv_valid[0];
    assign bus.req0_last  = drv_last[0];
    assign bus.req0_data  = drv_data[0];
    assign bus.req1_valid = drv_valid[1];
    assign bus.req1_last  = drv_last[1];
    assign bus.req1_data  = drv_data[1];

    word_t       pkt_q0[$], pkt_q1[$];
    logic [15:0] exp_q0[$], exp_q1[$];
    logic [1:0]  grant_log[$];
    int          gap_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int stb_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_word(input int r, input logic [15:0] d, input logic l, input int unsigned dly);
        word_t w;
        w.last = l;
        w.data = d;
        w.dly  = dly;
        if (r == 0) begin
            pkt_q0.push_back(w);
            exp_q0.push_back(d);
        end else begin
            pkt_q1.push_back(w);
            exp_q1.push_back(d);
        end
    endtask

    task automatic push_pkt_rand(input int r);
        int n;
        n = int'($urandom_range(1, 4));
        for (int i = 0; i < n; i++)
            push_word(r, 16'($urandom), (i == n - 1),
                      (i == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3));
    endtask

    function automatic int qsize(input int r);
        return (r == 0) ? pkt_q0.size() : pkt_q1.size();
    endfunction

    function automatic logic rdy(input int r);
        return (r == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    // Requester driver: presents queued words, holds each until ready, flushes on reset.
    task automatic drive(input int r);
        word_t w;
        bit    at_edge;
        bit    got;
        int    n;
        at_edge = 0;
        forever begin
            if (!at_edge) begin
                @(posedge clk_sys);
                #1;
            end
            at_edge = 0;
            if (!reset_n) begin
                drv_valid[r] = 1'b0;
                if (r == 0) pkt_q0.delete();
                else        pkt_q1.delete();
            end else if (qsize(r) == 0) begin
                drv_valid[r] = 1'b0;
            end else begin
                if (r == 0) w = pkt_q0.pop_front();
                else        w = pkt_q1.pop_front();
                if (w.dly != 0) begin
                    drv_valid[r] = 1'b0;
                    for (int unsigned i = 0; i < w.dly && reset_n; i++) begin
                        @(posedge clk_sys);
                        #1;
                    end
                end
                if (reset_n) begin
                    drv_valid[r] = 1'b1;
                    drv_data[r]  = w.data;
                    drv_last[r]  = w.last;
                    got = 0;
                    n   = 0;
                    while (!got && reset_n && n < 4000) begin
                        @(negedge clk_sys);
                        if (rdy(r)) got = 1;
                        else        n++;
                    end
                    if (reset_n) chk((r == 0) ? "req0_accept" : "req1_accept", 32'(got), 1);
                    if (got) begin
                        @(posedge clk_sys);
                        #1;
                        at_edge = 1;
                    end else begin
                        drv_valid[r] = 1'b0;
                    end
                end else begin
                    drv_valid[r] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        drv_valid[0] = 1'b0; drv_last[0] = 1'b0; drv_data[0] = '0;
        drv_valid[1] = 1'b0; drv_last[1] = 1'b0; drv_data[1] = '0;
    end
    initial drive(0);
    initial drive(1);

    // Monitor: arbitration reference model, word scoreboard and framing timing.
    logic        prev_osd = 1'b0, prev_stb = 1'b0, pv0 = 1'b0, pv1 = 1'b0;
    logic        seen_fall = 1'b0;
    logic        last_srv = 1'b1;
    logic [1:0]  cur_g = 2'b00;
    logic [1:0]  exp_g;
    logic [15:0] din_rise = '0;
    logic [15:0] e;
    int          hi_run = 0, low_run = 0;

    initial forever begin
        @(negedge clk_sys);
        if (!reset_n) begin
            prev_osd  = 1'b0;
            prev_stb  = 1'b0;
            seen_fall = 1'b0;
            last_srv  = 1'b1;
            hi_run    = 0;
            low_run   = 0;
        end else begin
            if (bus.grant != 2'b01) chk("rdy0_not_granted", 32'(bus.req0_ready), 0);
            if (bus.grant != 2'b10) chk("rdy1_not_granted", 32'(bus.req1_ready), 0);
            if (!bus.io_osd) chk("grant_outside_pkt", 32'(bus.grant), 0);

            if (bus.io_osd && !prev_osd) begin
                if (seen_fall) begin
                    chk("gap_len_min", 32'(low_run >= int'(GAPC) + 1), 1);
                    gap_log.push_back(low_run);
                end
                if (pv0 && pv1) begin
`ifdef OSD_ARB_PRIO_EN
                    exp_g = 2'b01;
`else
                    exp_g = last_srv ? 2'b01 : 2'b10;
`endif
                end else if (pv0) exp_g = 2'b01;
                else if (pv1)     exp_g = 2'b10;
                else              exp_g = 2'b00;
                cur_g    = exp_g;
                last_srv = (exp_g == 2'b10);
                grant_log.push_back(bus.grant);
            end
            if (bus.io_osd) begin
                chk("grant_owner", 32'(bus.grant), 32'(cur_g));
                chk("busy_in_pkt", 32'(bus.busy), 1);
            end

            if (bus.io_strobe && !prev_stb) begin
                stb_total++;
                din_rise = bus.io_din;
                hi_run   = 1;
                if (bus.grant == 2'b01) begin
                    chk("strobe_queue0", 32'(exp_q0.size() != 0), 1);
                    if (exp_q0.size() != 0) begin
                        e = exp_q0.pop_front();
                        chk("io_din_req0", 32'(bus.io_din), 32'(e));
                    end
                end else begin
                    chk("strobe_queue1", 32'(exp_q1.size() != 0), 1);
                    if (exp_q1.size() != 0) begin
                        e = exp_q1.pop_front();
                        chk("io_din_req1", 32'(bus.io_din), 32'(e));
                    end
                end
            end else if (bus.io_strobe) begin
                hi_run++;
                chk("din_stable", 32'(bus.io_din), 32'(din_rise));
            end
            if (!bus.io_strobe && prev_stb) chk("strobe_hi_len", 32'(hi_run), SHI);

            if (!bus.io_osd) begin
                if (prev_osd) begin
                    seen_fall = 1'b1;
                    low_run   = 1;
                end else begin
                    low_run++;
                end
            end
            prev_osd = bus.io_osd;
            prev_stb = bus.io_strobe;
        end
        pv0 = bus.req0_valid;
        pv1 = bus.req1_valid;
    end

    task automatic count_until(input int sel, input logic lvl, input int limit, output int n);
        logic s;
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
            case (sel)
                SEL_STB:  s = bus.io_strobe;
                SEL_OSD:  s = bus.io_osd;
                SEL_BUSY: s = bus.busy;
                SEL_V0:   s = bus.req0_valid;
                default:  s = bus.req0_ready;
            endcase
        end while (s !== lvl && n < limit);
    endtask

    task automatic wait_idle();
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < 20000) begin
            @(negedge clk_sys);
            n++;
            done = (pkt_q0.size() == 0) && (pkt_q1.size() == 0) &&
                   (exp_q0.size() == 0) && (exp_q1.size() == 0) &&
                   !bus.busy && !drv_valid[0] && !drv_valid[1];
        end
        chk("drain", 32'(done), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [1:0] exp_order [5];
    int n, n2, found, stb_before;

    initial begin
`ifdef OSD_ARB_PRIO_EN
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
`else
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
        repeat (3) @(negedge clk_sys);
        chk("rst_io_osd", 32'(bus.io_osd), 0);
        chk("rst_io_strobe", 32'(bus.io_strobe), 0);
        chk("rst_io_din", 32'(bus.io_din), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_abort_cnt", 32'(bus.abort_cnt), 0);
        reset_n = 1'b1;

        // Both requesters held valid from reset
        grant_log.delete();
        gap_log.delete();
        for (int p = 0; p < 3; p++) begin
            push_word(0, 16'(16'h0100 + p), 1'b0, 0);
            push_word(0, 16'(16'h0180 + p), 1'b1, 0);
        end
        for (int p = 0; p < 2; p++) begin
            push_word(1, 16'(16'h0200 + p), 1'b0, 0);
            push_word(1, 16'(16'h0280 + p), 1'b1, 0);
        end
        wait_idle();
        chk("contention_pkts", 32'(grant_log.size()), 5);
        for (int i = 0; i < 5; i++)
            if (i < grant_log.size()) chk("contention_order", 32'(grant_log[i]), 32'(exp_order[i]));
        chk("contention_gaps", 32'(gap_log.size()), 4);
        foreach (gap_log[i]) chk("contention_gap_len", 32'(gap_log[i]), GAPC + 1);

        // Three-word packet from req0: latency, word period, framing
        push_word(0, 16'h0020, 1'b0, 0);
        push_word(0, 16'h00AA, 1'b0, 0);
        push_word(0, 16'h0055, 1'b1, 0);
        count_until(SEL_V0, 1'b1, 20, n);
        count_until(SEL_STB, 1'b1, 20, n);
        chk("first_strobe_latency", 32'(n), 3);
        count_until(SEL_STB, 1'b0, 20, n);
        count_until(SEL_STB, 1'b1, 20, n2);
        chk("word_period_1", 32'(n + n2), 1 + SHI + SLO);
        count_until(SEL_STB, 1'b0, 20, n);
        count_until(SEL_STB, 1'b1, 20, n2);
        chk("word_period_2", 32'(n + n2), 1 + SHI + SLO);
        count_until(SEL_OSD, 1'b0, 20, n);
        chk("last_word_to_osd_fall", 32'(n), SHI + SLO);
        count_until(SEL_BUSY, 1'b0, 20, n);
        chk("gap_len", 32'(n), GAPC);
        wait_idle();
        chk("grant_after_pkt", 32'(bus.grant), 0);

        // Mid-packet stall longer than TIMEOUT
        push_word(0, 16'h0031, 1'b0, 0);
        push_word(0, 16'h0032, 1'b1, 300);
        count_until(SEL_R0, 1'b1, 50, n);
        count_until(SEL_OSD, 1'b0, 400, n);
        chk("abort_latency", 32'(n), SHI + SLO + TMO + 1);
        chk("abort_cnt_1", 32'(bus.abort_cnt), 1);
        wait_idle();
        chk("abort_cnt_hold", 32'(bus.abort_cnt), 1);

        // Single-word packet
        stb_before = stb_total;
        push_word(0, 16'h0041, 1'b1, 0);
        wait_idle();
        chk("single_strobe_count", 32'(stb_total - stb_before), 1);
        chk("single_din_hold", 32'(bus.io_din), 32'h0041);
        chk("single_osd_low", 32'(bus.io_osd), 0);

        // Reset during the HI phase of a data word
        push_word(0, 16'h0101, 1'b0, 0);
        push_word(0, 16'h0102, 1'b0, 0);
        push_word(0, 16'h0103, 1'b1, 0);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk_sys);
            if (bus.io_strobe && bus.io_din == 16'h0102) found = 1;
        end
        chk("reset_target_found", 32'(found), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_io_strobe", 32'(bus.io_strobe), 0);
        chk("arst_io_osd", 32'(bus.io_osd), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_grant", 32'(bus.grant), 0);
        repeat (3) @(negedge clk_sys);
        exp_q0.delete();
        exp_q1.delete();
        chk("arst_abort_cnt", 32'(bus.abort_cnt), 0);
        reset_n = 1'b1;
        push_word(0, 16'h0201, 1'b0, 0);
        push_word(0, 16'h0202, 1'b1, 0);
        wait_idle();
        chk("post_reset_din", 32'(bus.io_din), 32'h0202);

        // Randomized traffic from both requesters
        for (int k = 0; k < 24; k++) push_pkt_rand(int'($urandom_range(0, 1)));
        wait_idle();
        chk("random_no_abort", 32'(bus.abort_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
